// File: rtl/alu_pkg.sv
// Shared encodings for the ID-side ALU operation issue stage.
//   - ALUControl codes understood by the execute-stage ALU
//   - RV32I major opcodes that the decoder distinguishes
//   - SrcA select codes for the EX operand-A mux
//   - funct7 values that separate the base and alternate ALU operations
package alu_pkg;

  localparam logic [3:0] ALU_ADD     = 4'b0000;
  localparam logic [3:0] ALU_SUB     = 4'b0001;
  localparam logic [3:0] ALU_AND     = 4'b0010;
  localparam logic [3:0] ALU_OR      = 4'b0011;
  localparam logic [3:0] ALU_XOR     = 4'b0100;
  localparam logic [3:0] ALU_SLL     = 4'b0101;
  localparam logic [3:0] ALU_SRL     = 4'b0110;
  localparam logic [3:0] ALU_SRA     = 4'b0111;
  localparam logic [3:0] ALU_SLTU    = 4'b1000;
  localparam logic [3:0] ALU_SLT     = 4'b1001;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] SRCA_RD1  = 2'b00;
  localparam logic [1:0] SRCA_PC   = 2'b01;
  localparam logic [1:0] SRCA_ZERO = 2'b10;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Immediate shifts carry the shift amount in imm[4:0]; the upper
  // immediate bits hold funct7 and must not reach the ALU.
  function automatic logic is_imm_shift(input logic [6:0] opcode,
                                        input logic [2:0] funct3);
    return (opcode == OP_IMM) && (funct3 == 3'b001 || funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Purely combinational RV32I decode into ALU operation controls.
// Ports:
//   opcode_i / funct3_i / funct7_i : instruction fields from ID
//   alu_ctrl_o    : 4-bit ALUControl (ALU_ILLEGAL for bad encodings)
//   src_a_o       : operand-A select (RD1 / PC / zero)
//   src_b_o       : operand-B select (0 RD2, 1 ImmExt)
//   shamt_mask_o  : EX must mask SrcB to [4:0]
//   illegal_o     : unsupported R/I/branch encoding
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic [3:0] alu_ctrl_o,
  output logic [1:0] src_a_o,
  output logic       src_b_o,
  output logic       shamt_mask_o,
  output logic       illegal_o
);

  logic       is_shift;
  logic [3:0] base_op;   // funct3 map shared by R-type and I-ALU
  logic [3:0] op;
  logic       bad;

  always_comb begin
    is_shift = (funct3_i == 3'b001) || (funct3_i == 3'b101);
    case (funct3_i)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  end

  // NOTE: every output gets a default before the case so that no path
  // leaves a variable unassigned; a missing default infers a latch.
  always_comb begin
    op           = ALU_ADD;
    bad          = 1'b0;
    src_a_o      = SRCA_RD1;
    src_b_o      = 1'b0;
    shamt_mask_o = 1'b0;
    case (opcode_i)
      OP_R: begin
        shamt_mask_o = is_shift;
        if (funct7_i == F7_BASE)                         op  = base_op;
        else if (funct7_i == F7_ALT && funct3_i == 3'b000) op = ALU_SUB;
        else if (funct7_i == F7_ALT && funct3_i == 3'b101) op = ALU_SRA;
        else                                             bad = 1'b1;
      end
      OP_IMM: begin
        src_b_o      = 1'b1;
        shamt_mask_o = is_shift;
        if (funct3_i == 3'b001) begin
          if (funct7_i == F7_BASE) op = ALU_SLL;
          else                     bad = 1'b1;
        end else if (funct3_i == 3'b101) begin
          if (funct7_i == F7_BASE)     op  = ALU_SRL;
          else if (funct7_i == F7_ALT) op  = ALU_SRA;
          else                         bad = 1'b1;
        end else begin
          op = base_op;   // funct7 bits are immediate bits here
        end
      end
      OP_LOAD, OP_STORE, OP_JALR: src_b_o = 1'b1;
      OP_BRANCH: begin
        case (funct3_i[2:1])
          2'b00:   op  = ALU_SUB;   // BEQ/BNE use the Zero flag
          2'b10:   op  = ALU_SLT;
          2'b11:   op  = ALU_SLTU;
          default: bad = 1'b1;
        endcase
      end
      OP_LUI: begin
        src_a_o = SRCA_ZERO;
        src_b_o = 1'b1;
      end
      OP_AUIPC, OP_JAL: begin
        src_a_o = SRCA_PC;
        src_b_o = 1'b1;
      end
      default: src_a_o = SRCA_ZERO;   // FENCE/SYSTEM/unknown: harmless 0 + RD2
    endcase
    alu_ctrl_o = bad ? ALU_ILLEGAL : op;
    illegal_o  = bad;
  end

endmodule

// File: rtl/alu_op_issue_stage.sv
// ID/EX pipeline register for the ALU operation interface.
// Decodes InstrD, then registers the ALU controls together with
// RD1/RD2/ImmExt/PC. Priority per edge: reset > FlushE > StallE > load;
// ValidD=0 loads a bubble.
// Ports:
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   InstrD, ValidD    : instruction in ID and its valid flag
//   RD1D, RD2D        : register file read data
//   ImmExtD, PCD      : extended immediate and PC of InstrD
//   StallE, FlushE    : hold / bubble the ID/EX register
//   ALUControlE, ALUSrcAE, ALUSrcBE, ShamtMaskE : registered ALU controls
//   RD1E, RD2E, ImmExtE, PCE                     : registered operands
//   ValidE, IllegalE                             : slot status
module alu_op_issue_stage
  import alu_pkg::*;
#(
  parameter int         XLEN      = 32,
  parameter logic [3:0] BUBBLE_OP = 4'b0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     InstrD,
  input  logic            ValidD,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [XLEN-1:0] PCD,
  input  logic            StallE,
  input  logic            FlushE,
  output logic [3:0]      ALUControlE,
  output logic [1:0]      ALUSrcAE,
  output logic            ALUSrcBE,
  output logic            ShamtMaskE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic            ValidE,
  output logic            IllegalE
);

  typedef struct packed {
    logic [3:0]      alu_ctrl;
    logic [1:0]      src_a;
    logic            src_b;
    logic            shamt_mask;
    logic            valid;
    logic            illegal;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } idex_t;

  idex_t e_q, e_d, bubble, load;

  logic [3:0] dec_ctrl;
  logic [1:0] dec_src_a;
  logic       dec_src_b, dec_shamt, dec_illegal;

  // Register specifiers are consumed by the hazard unit, not here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{InstrD[24:15], InstrD[11:7]};

  alu_op_decoder u_decoder (
    .opcode_i     (InstrD[6:0]),
    .funct3_i     (InstrD[14:12]),
    .funct7_i     (InstrD[31:25]),
    .alu_ctrl_o   (dec_ctrl),
    .src_a_o      (dec_src_a),
    .src_b_o      (dec_src_b),
    .shamt_mask_o (dec_shamt),
    .illegal_o    (dec_illegal)
  );

  always_comb begin
    bubble          = '0;
    bubble.alu_ctrl = BUBBLE_OP;

    load            = '0;
    load.alu_ctrl   = dec_ctrl;
    load.src_a      = dec_src_a;
    load.src_b      = dec_src_b;
    load.shamt_mask = dec_shamt;
    load.valid      = 1'b1;
    load.illegal    = dec_illegal;
    load.rd1        = RD1D;
    load.rd2        = RD2D;
    load.imm        = ImmExtD;
    load.pc         = PCD;
    if (is_imm_shift(InstrD[6:0], InstrD[14:12])) load.imm[XLEN-1:5] = '0;

    e_d = e_q;
    if (FlushE)       e_d = bubble;   // flush beats stall
    else if (!StallE) e_d = ValidD ? load : bubble;
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  // The operand registers are reset too, so a bubble never exposes
  // stale data on RD1E/RD2E/ImmExtE/PCE.
  always_ff @(posedge clk) begin
    if (reset) e_q <= bubble;
    else       e_q <= e_d;
  end

  assign ALUControlE = e_q.alu_ctrl;
  assign ALUSrcAE    = e_q.src_a;
  assign ALUSrcBE    = e_q.src_b;
  assign ShamtMaskE  = e_q.shamt_mask;
  assign ValidE      = e_q.valid;
  assign IllegalE    = e_q.illegal;
  assign RD1E        = e_q.rd1;
  assign RD2E        = e_q.rd2;
  assign ImmExtE     = e_q.imm;
  assign PCE         = e_q.pc;

endmodule

// File: tb/tb_alu_op_issue_stage.sv
// Self-checking bench for alu_op_issue_stage: directed steps from the
// test plan followed by randomized traffic, all compared against a
// table-driven reference model of the ID/EX register.
module tb_alu_op_issue_stage;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [31:0]     InstrD;
  logic            ValidD;
  logic [XLEN-1:0] RD1D, RD2D, ImmExtD, PCD;
  logic            StallE, FlushE;
  logic [3:0]      ALUControlE;
  logic [1:0]      ALUSrcAE;
  logic            ALUSrcBE, ShamtMaskE, ValidE, IllegalE;
  logic [XLEN-1:0] RD1E, RD2E, ImmExtE, PCE;

  always #5 clk = ~clk;

  alu_op_issue_stage #(.XLEN(XLEN), .BUBBLE_OP(4'b0000)) dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .ValidD(ValidD),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD),
    .StallE(StallE), .FlushE(FlushE),
    .ALUControlE(ALUControlE), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
    .ShamtMaskE(ShamtMaskE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .PCE(PCE), .ValidE(ValidE), .IllegalE(IllegalE)
  );

  typedef struct {
    logic [3:0]  ctrl;
    logic [1:0]  srca;
    logic        srcb;
    logic        shamt;
    logic        valid;
    logic        illegal;
    logic [31:0] rd1, rd2, imm, pc;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t model;

  // ALUControl for funct3 0..7 with funct7=0000000 (R-type and I-ALU).
  logic [3:0] base_tbl [8] = '{4'h0, 4'h5, 4'h9, 4'h8, 4'h4, 4'h6, 4'h3, 4'h2};
  // Branch funct3 0..7: BEQ/BNE SUB, 01x illegal, BLT/BGE SLT, BLTU/BGEU SLTU.
  logic [3:0] br_tbl   [8] = '{4'h1, 4'h1, 4'hF, 4'hF, 4'h9, 4'h9, 4'h8, 4'h8};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t bubble_val();
    exp_t b;
    b = '{ctrl: 4'h0, srca: 2'b00, srcb: 1'b0, shamt: 1'b0, valid: 1'b0,
          illegal: 1'b0, rd1: 32'h0, rd2: 32'h0, imm: 32'h0, pc: 32'h0};
    return b;
  endfunction

  // What a loaded instruction should put in the EX slot.
  function automatic exp_t decode_model(input logic [31:0] instr, input logic [31:0] rd1,
                                        input logic [31:0] rd2, input logic [31:0] imm,
                                        input logic [31:0] pc);
    exp_t e;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic       shift;
    opc = instr[6:0]; f3 = instr[14:12]; f7 = instr[31:25];
    shift = (f3 == 3'd1) || (f3 == 3'd5);
    e = '{ctrl: 4'h0, srca: 2'b00, srcb: 1'b0, shamt: 1'b0, valid: 1'b1,
          illegal: 1'b0, rd1: rd1, rd2: rd2, imm: imm, pc: pc};
    if (opc == 7'h33) begin
      e.shamt = shift;
      if (f7 == 7'h00)                   e.ctrl = base_tbl[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) e.ctrl = 4'h1;
      else if (f7 == 7'h20 && f3 == 3'd5) e.ctrl = 4'h7;
      else                               e.illegal = 1'b1;
    end else if (opc == 7'h13) begin
      e.srcb  = 1'b1;
      e.shamt = shift;
      if (shift) begin
        e.imm = imm & 32'h1F;
        if (f7 == 7'h00)                    e.ctrl = base_tbl[f3];
        else if (f7 == 7'h20 && f3 == 3'd5) e.ctrl = 4'h7;
        else                                e.illegal = 1'b1;
      end else e.ctrl = base_tbl[f3];
    end else if (opc == 7'h03 || opc == 7'h23 || opc == 7'h67) begin
      e.srcb = 1'b1;
    end else if (opc == 7'h63) begin
      e.ctrl = br_tbl[f3];
      e.illegal = (br_tbl[f3] == 4'hF);
    end else if (opc == 7'h37) begin
      e.srca = 2'b10; e.srcb = 1'b1;
    end else if (opc == 7'h17 || opc == 7'h6F) begin
      e.srca = 2'b01; e.srcb = 1'b1;
    end else begin
      e.srca = 2'b10;
    end
    if (e.illegal) e.ctrl = 4'hF;
    return e;
  endfunction

  // One clock edge: advance the model from the inputs seen at the edge,
  // then compare every output 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    if (reset)        model = bubble_val();
    else if (FlushE)  model = bubble_val();
    else if (StallE)  model = model;
    else if (!ValidD) model = bubble_val();
    else              model = decode_model(InstrD, RD1D, RD2D, ImmExtD, PCD);
    #1;
    check({tag, ".ctrl"},    {28'h0, ALUControlE}, {28'h0, model.ctrl});
    check({tag, ".valid"},   {31'h0, ValidE},      {31'h0, model.valid});
    check({tag, ".illegal"}, {31'h0, IllegalE},    {31'h0, model.illegal});
    check({tag, ".rd1"},     RD1E,                 model.rd1);
    check({tag, ".rd2"},     RD2E,                 model.rd2);
    check({tag, ".imm"},     ImmExtE,              model.imm);
    check({tag, ".pc"},      PCE,                  model.pc);
    // Operand selects of an illegal slot are don't-care.
    if (!model.illegal) begin
      check({tag, ".srca"},  {30'h0, ALUSrcAE},    {30'h0, model.srca});
      check({tag, ".srcb"},  {31'h0, ALUSrcBE},    {31'h0, model.srcb});
      check({tag, ".shamt"}, {31'h0, ShamtMaskE},  {31'h0, model.shamt});
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic v, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] im, input logic [31:0] p);
    InstrD = instr; ValidD = v; RD1D = r1; RD2D = r2; ImmExtD = im; PCD = p;
  endtask

  logic [6:0] opc_pool [12] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37,
                                7'h17, 7'h6F, 7'h67, 7'h0F, 7'h73, 7'h33};

  initial begin
    model  = bubble_val();
    reset  = 1'b1; StallE = 1'b0; FlushE = 1'b0;
    drive(32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);

    // Reset held two cycles, then released with no valid input.
    step("reset0");
    step("reset1");
    reset = 1'b0;
    drive(32'h40208033, 1'b0, 32'hDEAD, 32'hBEEF, 32'h1234, 32'h40);
    step("idle");
    check("idle.lit_ctrl", {28'h0, ALUControlE}, 32'h0);

    // R-type SUB.
    drive(32'h40208033, 1'b1, 32'd5, 32'd3, 32'h0, 32'h44);
    step("sub");
    check("sub.lit_ctrl", {28'h0, ALUControlE}, 32'h1);
    check("sub.lit_rd1",  RD1E, 32'd5);

    // SRAI x1,x2,3 with funct7 bits still in the immediate.
    drive(32'h40315093, 1'b1, 32'h80000000, 32'h0, 32'h00000403, 32'h48);
    step("srai");
    check("srai.lit_ctrl", {28'h0, ALUControlE}, 32'h7);
    check("srai.lit_imm",  ImmExtE, 32'h3);

    // R-type with funct7=0000001 is illegal; operands still load.
    drive(32'h02208033, 1'b1, 32'h11, 32'h22, 32'h33, 32'h4C);
    step("rillegal");
    check("rillegal.lit_ctrl", {28'h0, ALUControlE}, 32'hF);

    // BLTU, then AUIPC.
    drive(32'h0020E463, 1'b1, 32'h7, 32'h9, 32'h8, 32'h50);
    step("bltu");
    drive(32'h00001097, 1'b1, 32'h0, 32'h0, 32'h1000, 32'h100);
    step("auipc");
    check("auipc.lit_pc", PCE, 32'h100);

    // Load, then 3 stall cycles while ID moves on to XOR.
    drive(32'h00412083, 1'b1, 32'h1000, 32'h0, 32'h4, 32'h104);
    step("lw");
    StallE = 1'b1;
    drive(32'h0020C0B3, 1'b1, 32'hF0F0, 32'h0FF0, 32'h0, 32'h108);
    for (int i = 0; i < 3; i++) step("stall");
    check("stall.lit_ctrl", {28'h0, ALUControlE}, 32'h0);
    check("stall.lit_rd1",  RD1E, 32'h1000);
    StallE = 1'b0;
    step("xor");
    check("xor.lit_ctrl", {28'h0, ALUControlE}, 32'h4);

    // Flush and stall together on a valid AND: flush wins.
    drive(32'h0020F0B3, 1'b1, 32'h3, 32'h5, 32'h0, 32'h10C);
    FlushE = 1'b1; StallE = 1'b1;
    step("flush_stall");
    check("flush_stall.lit_valid", {31'h0, ValidE}, 32'h0);
    FlushE = 1'b0; StallE = 1'b0;

    // Load an AND, stall, then reset mid-stall.
    step("and");
    StallE = 1'b1;
    step("and_hold");
    reset = 1'b1;
    step("stall_reset");
    check("stall_reset.lit_rd2", RD2E, 32'h0);
    reset = 1'b0; StallE = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      logic [6:0]  f7;
      ins = $urandom;
      ins[6:0] = opc_pool[$urandom_range(0, 11)];
      case ($urandom_range(0, 2))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      ins[31:25] = f7;
      drive(ins, ($urandom_range(0, 7) != 0), $urandom, $urandom, $urandom, $urandom);
      StallE = ($urandom_range(0, 5) == 0);
      FlushE = ($urandom_range(0, 9) == 0);
      reset  = ($urandom_range(0, 49) == 0);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
